fifo_wr_arbiter: RTL and testbench

// - Shares the single write port of asyn_fifo among NUM_REQ requesters in the wr_clk domain.
// - Round-robin arbitration with bounded bursts: the owner writes up to MAX_BURST beats, then ownership rotates.
// - Drives the FIFO wr_en/wdata directly. Uses FIFO full to stall grants, so asyn_fifo overflow never asserts.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int own_w(input int num_req);
        return (num_req > 32'sd1) ? $clog2(num_req) : 32'sd1;
    endfunction

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 32'sd1);
    endfunction

    // Widths for the default configuration (4 requesters, 4-beat bursts).
    localparam int OWN_W = own_w(32'sd4);
    localparam int CNT_W = cnt_w(32'sd4);

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: nearest requester after the last owner, cyclically.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int OW      = own_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last,
    output logic [OW-1:0]      idx,
    output logic               valid
);

    int best_s;
    int dist_s;

    // Pick the active requester with the smallest cyclic distance past last.
    always_comb begin
        idx    = last;
        valid  = 1'b0;
        best_s = NUM_REQ;
        dist_s = 32'sd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + NUM_REQ - int'(last) - 32'sd1) % NUM_REQ;
            if (req[i] && (dist_s < best_s)) begin
                best_s = dist_s;
                idx    = OW'(i);
                valid  = 1'b1;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, bounded-burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional feature macro FIFO_ARB_STATS_EN adds per-requester saturating beat counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 4,
    localparam int OW        = own_w(NUM_REQ),
    localparam int CW        = cnt_w(MAX_BURST)
) (
    input  logic                     wr_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     full,
`ifdef FIFO_ARB_STATS_EN
    input  logic                     stats_clr,
    output logic [NUM_REQ*16-1:0]    beat_total,
`endif
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wdata,
    output logic                     busy,
    output logic [OW-1:0]            owner
);

    arb_state_t        state_r;
    logic [CW-1:0]     beat_cnt_r;
    logic [OW-1:0]     owner_r;
    logic              busy_r;

    logic [OW-1:0]     pick_idx_s;
    logic              pick_valid_s;
    logic              own_req_s;
    logic [WIDTH-1:0]  own_data_s;
    logic              accept_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req),
        .last  (owner_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Select the current owner's request bit and data slice.
    always_comb begin
        own_req_s  = 1'b0;
        own_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_r == OW'(i)) begin
                own_req_s  = req[i];
                own_data_s = req_data[i*WIDTH +: WIDTH];
            end else begin
                own_req_s  = own_req_s;
                own_data_s = own_data_s;
            end
        end
    end

    // Zero-latency grant: the FIFO captures the beat on the same edge; reset suppresses it.
    always_comb begin
        accept_s = (state_r == BURST) && !rst && own_req_s && !full;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = accept_s && (owner_r == OW'(i));
        end
        wr_en = accept_s;
        if (accept_s) begin
            wdata = own_data_s;
        end else begin
            wdata = '0;
        end
    end

    // Arbitration FSM: IDLE picks the next owner, BURST streams up to MAX_BURST beats.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_r    <= OW'(NUM_REQ - 1);
            beat_cnt_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        owner_r    <= pick_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= BURST;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end
                end
                BURST: begin
                    if (!own_req_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + CW'(1);
                        if (beat_cnt_r == CW'(MAX_BURST - 1)) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= BURST;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= BURST;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign owner = owner_r;
    assign busy  = busy_r;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] beat_total_r [NUM_REQ];

    // Per-requester beat counters; clear wins over a simultaneous beat.
    always_ff @(posedge wr_clk) begin
        if (rst || stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beat_total_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beat_total_r[i] <= gnt[i] ? sat_inc16(beat_total_r[i]) : beat_total_r[i];
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        beat_total = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_total[i*16 +: 16] = beat_total_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, scoreboard-based bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, WIDTH=16).
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;

    typedef struct packed {
        logic [NR-1:0] g;
        logic [W-1:0]  d;
    } exp_t;

    logic              wr_clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     gnt;
    logic              full;
    logic              wr_en;
    logic [W-1:0]      wdata;
    logic              busy;
    logic [1:0]        owner;
`ifdef FIFO_ARB_STATS_EN
    logic              stats_clr;
    logic [NR*16-1:0]  beat_total;
`endif

    exp_t        exp_q [$];
    logic [W-1:0] src_q [NR][$];
    int          checks   = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic [31:0] we_hist  = 32'h0;

    fifo_wr_arbiter #(
        .WIDTH     (W),
        .NUM_REQ   (NR),
        .MAX_BURST (4)
    ) dut (
`ifdef FIFO_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .beat_total (beat_total),
`endif
        .wr_clk   (wr_clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .full     (full),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += src_q[i].size();
        return n;
    endfunction

    // Requesters present the head of their queue; req drops only when nothing is pending.
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i] = (src_q[i].size() > 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0000;
        end
    endtask

    task automatic beat(input int i, input logic [W-1:0] d);
        exp_t e;
        src_q[i].push_back(d);
        e.g = 4'b0001 << i;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_beat(input int i, input logic [W-1:0] d);
        exp_t e;
        e.g = 4'b0001 << i;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // One clock: check outputs at the falling edge, then retire granted beats after the rising edge.
    task automatic cyc();
        exp_t e;
        logic [NR-1:0] gs;
        @(negedge wr_clk);
        gs = gnt;
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("wr_en_vs_gnt", 32'(wr_en), 32'(|gnt));
        if (wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("sb_empty_on_write", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.g));
                chk("wdata", 32'(wdata), 32'(e.d));
            end
        end
        we_hist = {we_hist[30:0], wr_en};
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (gs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (pending() > 0 && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("drain_pending", 32'(pending()), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        cyc();
        cyc();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd3);
        rst      = 1'b0;
        we_hist  = 32'h0;
        wr_count = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        req      = '0;
        req_data = '0;
        full     = 1'b0;
        rst      = 1'b1;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(posedge wr_clk);
        #1;

        // Single requester: bursts of 4, one bubble, then the remaining 2.
        do_reset();
        for (int d = 1; d <= 6; d++) beat(0, 16'(d));
        drive();
        drain(50);
        cyc();
        chk("single_pattern", {23'h0, we_hist[8:0]}, 32'b011110110);
        chk("single_busy_end", 32'(busy), 32'd0);
        chk("single_owner", 32'(owner), 32'd0);

        // Round robin with all four requesting: owners 0,1,2,3,0,1,2,3, four beats each.
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(16'(i*256 + k));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < 4; k++) expect_beat(i, 16'(i*256 + r*4 + k));
        drive();
        drain(200);
        chk("rr_total", 32'(wr_count), 32'd32);

        // Full stall after beat 2 for five cycles.
        do_reset();
        for (int k = 1; k <= 4; k++) beat(0, 16'hA000 + 16'(k));
        drive();
        n = 0;
        while (wr_count < 2 && n < 20) begin
            cyc();
            n++;
        end
        chk("stall_reach_2", 32'(wr_count), 32'd2);
        full = 1'b1;
        c0 = wr_count;
        repeat (5) cyc();
        chk("stall_no_write", 32'(wr_count), 32'(c0));
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_owner", 32'(owner), 32'd0);
        full = 1'b0;
        cyc();
        chk("stall_resume", 32'(wr_count), 32'(c0 + 1));
        drain(20);
        chk("stall_total", 32'(wr_count), 32'd4);

        // Early release: owner 2 has one beat, then owner 3 takes over.
        do_reset();
        beat(2, 16'h2222);
        beat(3, 16'h3331);
        beat(3, 16'h3332);
        drive();
        drain(30);
        cyc();
        chk("early_pattern", {25'h0, we_hist[6:0]}, 32'b0100110);
        chk("early_owner", 32'(owner), 32'd3);

        // Reset while owner 1 is two beats into its burst.
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 4; k++) src_q[i].push_back(16'(16'h4000 + i*16 + k));
        for (int k = 0; k < 4; k++) expect_beat(0, 16'(16'h4000 + k));
        for (int k = 0; k < 2; k++) expect_beat(1, 16'(16'h4010 + k));
        drive();
        n = 0;
        while (wr_count < 6 && n < 30) begin
            cyc();
            n++;
        end
        chk("pre_rst_owner", 32'(owner), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge wr_clk);
        chk("rst_cycle_wr_en", 32'(wr_en), 32'd0);
        chk("rst_cycle_gnt", 32'(gnt), 32'd0);
        @(posedge wr_clk);
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd3);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sb", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        rst = 1'b0;
        src_q[1].push_back(16'h5101);
        src_q[0].push_back(16'h5001);
        expect_beat(0, 16'h5001);
        expect_beat(1, 16'h5101);
        drive();
        drain(30);

`ifdef FIFO_ARB_STATS_EN
        // Statistics: saturate requester 0 and clear.
        do_reset();
        chk("stats_rst", 32'(beat_total[15:0]), 32'd0);
        for (int k = 0; k < 70000; k++) beat(0, 16'(k));
        drive();
        drain(90000);
        chk("stats_sat", 32'(beat_total[15:0]), 32'h0000FFFF);
        chk("stats_other", 32'(beat_total[31:16]), 32'd0);
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        chk("stats_clr", 32'(beat_total[15:0]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
